// File: rtl/psx_pkg.sv
// Shared encodings for the PSX controller poll master: FSM states and frame byte constants.
package psx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_BIT_LO   = 3'd2,
        ST_BIT_HI   = 3'd3,
        ST_ACK_WAIT = 3'd4,
        ST_GAP      = 3'd5,
        ST_FINISH   = 3'd6
    } psx_state_e;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_POLL   = 8'h42;
    localparam logic [7:0] CMD_IDLE   = 8'h00;
    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] MARKER     = 8'h5A;
    localparam logic [2:0] LAST_BYTE  = 3'd4;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_START;
            3'd1:    b = CMD_POLL;
            default: b = CMD_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// Byte shifter: drives cmd LSB first, samples synchronized data into the receive register.
// Strobe-driven by the poll master; cmd forced high whenever the frame is idle.
module psx_byte_xfer
    import psx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       drive_i,
    input  logic       sample_i,
    input  logic       idle_i,
    input  logic       data_i,
    output logic       cmd_o,
    output logic [7:0] rx_byte_o,
    output logic [7:0] rx_next_o
);

    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       cmd_q, cmd_d;

    assign rx_next_o = {data_i, rx_q[7:1]};
    assign rx_byte_o = rx_q;
    assign cmd_o     = cmd_q;

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cmd_d = cmd_q;
        if (sample_i) begin
            rx_d = rx_next_o;
            tx_d = {1'b1, tx_q[7:1]};
        end
        // Bit 0 of a fresh byte goes straight to cmd; later bits come from the shifted copy.
        if (load_i) begin
            tx_d  = tx_byte_i;
            rx_d  = '0;
            cmd_d = tx_byte_i[0];
        end else if (drive_i) begin
            cmd_d = tx_q[0];
        end
        if (idle_i) begin
            cmd_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cmd_q <= 1'b1;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cmd_q <= cmd_d;
        end
    end

endmodule

// File: rtl/psx_poll_master.sv
// Periodically polls a PSX digital controller (5-byte frame) and publishes the button word.
// Frame timing set by HALF_BIT/ATT_SETUP; aborts on ack timeout or bad ID/marker.
module psx_poll_master
    import psx_pkg::*;
#(
    parameter int HALF_BIT    = 4,
    parameter int ATT_SETUP   = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int POLL_PERIOD = 4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        data,
    input  logic        ack,
    output logic        att,
    output logic        psx_clk,
    output logic        cmd,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        err
);

    localparam int CNT_MAX0 = (HALF_BIT > ATT_SETUP) ? HALF_BIT : ATT_SETUP;
    localparam int CNT_MAX  = (CNT_MAX0 > ACK_TIMEOUT) ? CNT_MAX0 : ACK_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int POLL_W   = $clog2(POLL_PERIOD + 1);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(ATT_SETUP - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

    psx_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [2:0]        byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        b3_q, b3_d;
    logic [15:0]       buttons_q, buttons_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              att_q, att_d;
    logic              psx_clk_q, psx_clk_d;
    logic              data_s1_q, data_s2_q;
    logic              ack_s1_q, ack_s2_q;

    logic              load, drive, sample, cmd_idle;
    logic [2:0]        load_idx;
    logic [7:0]        rx_byte, rx_next;

    psx_byte_xfer u_xfer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .tx_byte_i (cmd_byte(load_idx)),
        .drive_i   (drive),
        .sample_i  (sample),
        .idle_i    (cmd_idle),
        .data_i    (data_s2_q),
        .cmd_o     (cmd),
        .rx_byte_o (rx_byte),
        .rx_next_o (rx_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        poll_d    = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;
        byte_d    = byte_q;
        bit_d     = bit_q;
        b3_d      = b3_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        load      = 1'b0;
        drive     = 1'b0;
        sample    = 1'b0;
        load_idx  = byte_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable && poll_q == POLL_LAST) begin
                    state_d = ST_SETUP;
                    poll_d  = '0;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d  = ST_BIT_LO;
                    cnt_d    = '0;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    sample  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BIT_HI;
                    // Header bytes are judged on the byte including the bit just sampled.
                    if (bit_q == 3'd7) begin
                        if (byte_q == 3'd3) begin
                            b3_d = rx_next;
                        end
                        if ((byte_q == 3'd1 && rx_next != ID_DIGITAL) ||
                            (byte_q == 3'd2 && rx_next != MARKER)) begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        drive   = 1'b1;
                        state_d = ST_BIT_LO;
                    end else if (byte_q == LAST_BYTE) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ACK_WAIT;
                    end
                end
            end
            ST_ACK_WAIT: begin
                if (!ack_s2_q) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d  = ST_BIT_LO;
                    cnt_d    = '0;
                    byte_d   = byte_q + 3'd1;
                    bit_d    = '0;
                    load     = 1'b1;
                    load_idx = byte_q + 3'd1;
                end
            end
            ST_FINISH: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                buttons_d = ~{rx_byte, b3_q};
                valid_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus pins are registered from the next state so att/cmd/psx_clk switch together.
        att_d     = (state_d == ST_IDLE);
        psx_clk_d = (state_d != ST_BIT_LO);
        cmd_idle  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            poll_q    <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            b3_q      <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            att_q     <= 1'b1;
            psx_clk_q <= 1'b1;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            b3_q      <= b3_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            att_q     <= att_d;
            psx_clk_q <= psx_clk_d;
            data_s1_q <= data;
            data_s2_q <= data_s1_q;
            ack_s1_q  <= ack;
            ack_s2_q  <= ack_s1_q;
        end
    end

    assign att     = att_q;
    assign psx_clk = psx_clk_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_psx_poll_master.sv
// Bench for psx_poll_master: controller model on the bus, scoreboard of expected frame outcomes.
module tb_psx_poll_master;

    localparam int HALF_BIT    = 4;
    localparam int ATT_SETUP   = 8;
    localparam int ACK_TIMEOUT = 32;
    localparam int POLL_PERIOD = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        data = 1'b1;
    logic        ack = 1'b1;
    logic        att, psx_clk, cmd, valid, err;
    logic [15:0] buttons;

    psx_poll_master #(
        .HALF_BIT    (HALF_BIT),
        .ATT_SETUP   (ATT_SETUP),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .data    (data),
        .ack     (ack),
        .att     (att),
        .psx_clk (psx_clk),
        .cmd     (cmd),
        .buttons (buttons),
        .valid   (valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [15:0] btn;
        int          bits;
        logic        chk_tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   viol = 0;

    logic [7:0] reply [5];
    logic [7:0] cap [5];
    logic [4:0] ack_en = 5'b01111;
    logic       spur = 1'b0;
    int         dev_byte = 0, dev_bit = 0, fall_count = 0, ack_cnt = 0;
    int         byte_end_cyc [5];
    logic       att_p = 1'b1, clk_p = 1'b1, valid_p = 1'b0, err_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [15:0] btn, input int bits, input logic tmo);
        exp_t e;
        e.is_err  = is_err;
        e.btn     = btn;
        e.bits    = bits;
        e.chk_tmo = tmo;
        sb.push_back(e);
    endtask

    // Controller model plus output monitor, both sampled on the falling clk edge.
    always @(negedge clk) begin
        exp_t e;
        if (ack_cnt > 0) ack_cnt--;
        if (att_p && !att) begin
            dev_byte   = 0;
            dev_bit    = 0;
            fall_count = 0;
            for (int i = 0; i < 5; i++) cap[i] = 8'h00;
        end
        if (!att_p && att) begin
            data     = 1'b1;
            ack_cnt  = 0;
            dev_byte = 0;
            dev_bit  = 0;
        end
        if (!att && clk_p && !psx_clk) begin
            fall_count++;
            if (dev_byte < 5 && dev_bit < 8) begin
                data = reply[dev_byte][dev_bit];
                cap[dev_byte][dev_bit] = cmd;
            end
            dev_bit++;
        end
        if (!att && !clk_p && psx_clk) begin
            if (spur && dev_byte == 0 && dev_bit == 3) ack_cnt = 3;
            if (dev_bit == 8) begin
                if (dev_byte < 5) begin
                    byte_end_cyc[dev_byte] = cyc;
                    if (ack_en[dev_byte]) ack_cnt = 7;
                end
                dev_byte++;
                dev_bit = 0;
            end
        end
        ack = !(ack_cnt >= 1 && ack_cnt <= 3);

        if (att && !cmd) viol++;
        if (valid && err) viol++;
        if (valid && valid_p) viol++;
        if (err && err_p) viol++;

        if (!rst && (valid || err)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {38'b0, valid, err}, 40'd0);
            end else begin
                e = sb.pop_front();
                check_eq("kind", {39'b0, err}, {39'b0, e.is_err});
                check_eq("buttons", {24'b0, buttons}, {24'b0, e.btn});
                check_eq("bits_clocked", fall_count, e.bits);
                if (!e.is_err) begin
                    check_eq("cmd_stream", {cap[0], cap[1], cap[2], cap[3], cap[4]}, 40'h0142000000);
                end else begin
                    check_eq("att_abort", {39'b0, att}, 40'd1);
                    check_eq("psxclk_abort", {39'b0, psx_clk}, 40'd1);
                end
                if (e.chk_tmo) check_eq("tmo_latency", cyc - byte_end_cyc[1], HALF_BIT + ACK_TIMEOUT);
            end
        end
        att_p   = att;
        clk_p   = psx_clk;
        valid_p = valid;
        err_p   = err;
    end

    task automatic wait_att_fall(output int n);
        n = 0;
        while (att && n < 3 * POLL_PERIOD) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 2 * POLL_PERIOD) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        #22;
        check_eq("rst_att", {39'b0, att}, 40'd1);
        check_eq("rst_psx_clk", {39'b0, psx_clk}, 40'd1);
        check_eq("rst_cmd", {39'b0, cmd}, 40'd1);
        check_eq("rst_buttons", {24'b0, buttons}, 40'd0);
        check_eq("rst_valid", {39'b0, valid}, 40'd0);
        check_eq("rst_err", {39'b0, err}, 40'd0);

        // Nominal frame straight out of reset
        enable = 1'b1;
        push_exp(1'b0, 16'h0001, 40, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_att_fall(n);
        check_eq("first_start", n, POLL_PERIOD);
        wait_done("frame1_done");

        reply = '{8'hFF, 8'h41, 8'h5A, 8'h00, 8'h80};
        push_exp(1'b0, 16'h7FFF, 40, 1'b0);
        wait_done("frame2_done");

        // Spurious ack inside byte 0
        spur  = 1'b1;
        reply = '{8'hFF, 8'h41, 8'h5A, 8'h5A, 8'hA5};
        push_exp(1'b0, 16'h5AA5, 40, 1'b0);
        wait_done("spur_done");
        spur = 1'b0;

        // Ack withheld after byte 1
        ack_en = 5'b01101;
        push_exp(1'b1, 16'h5AA5, 16, 1'b1);
        wait_done("tmo_done");
        ack_en = 5'b01111;

        // Wrong controller ID
        reply[1] = 8'h73;
        push_exp(1'b1, 16'h5AA5, 16, 1'b0);
        wait_done("badid_done");

        // Reset during byte 3
        reply = '{8'hFF, 8'h41, 8'h5A, 8'h12, 8'h34};
        n = 0;
        while (dev_byte != 3 && n < 2 * POLL_PERIOD) begin
            @(posedge clk);
            n++;
        end
        check_eq("reach_byte3", dev_byte, 3);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_att", {39'b0, att}, 40'd1);
        check_eq("midrst_psx_clk", {39'b0, psx_clk}, 40'd1);
        check_eq("midrst_cmd", {39'b0, cmd}, 40'd1);
        check_eq("midrst_buttons", {24'b0, buttons}, 40'd0);
        repeat (2) @(posedge clk);
        push_exp(1'b0, 16'hCBED, 40, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_att_fall(n);
        check_eq("restart_after_rst", n, POLL_PERIOD);
        wait_done("post_rst_done");

        // enable held low from reset
        #2 rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (3 * POLL_PERIOD) begin
            @(posedge clk);
            #1;
            if (!att) n++;
        end
        check_eq("en0_quiet", n, 0);

        // enable dropped mid-frame: frame still completes
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        push_exp(1'b0, 16'h0001, 40, 1'b0);
        enable = 1'b1;
        wait_att_fall(n);
        check_eq("en_start", n, 1);
        repeat (20) @(posedge clk);
        enable = 1'b0;
        wait_done("en_drop_done");
        n = 0;
        repeat (2 * POLL_PERIOD) begin
            @(posedge clk);
            #1;
            if (!att) n++;
        end
        check_eq("no_restart", n, 0);

        check_eq("invariants", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
